// File: rtl/dec2bin_pkg.sv
// dec2bin_pkg
//   Shared constants and types for the BCD time -> binary centisecond decoder.
//   Holds the FSM state enum, the mixed-radix table used by the Horner
//   accumulation, digit legality limits, digit-index constants for slicing
//   the 32-bit HH:MM:SS:CC word, and the shift-add multiply helper.
package dec2bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int WORD_W     = NUM_DIGITS * DIGIT_W;

    // Digit positions inside bcd_in; digit i occupies [4*i+3 : 4*i].
    localparam int DIG_CS_ONES  = 0;
    localparam int DIG_CS_TENS  = 1;
    localparam int DIG_SEC_ONES = 2;
    localparam int DIG_SEC_TENS = 3;
    localparam int DIG_MIN_ONES = 4;
    localparam int DIG_MIN_TENS = 5;
    localparam int DIG_HR_ONES  = 6;
    localparam int DIG_HR_TENS  = 7;

    // Legality limits.
    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS60_MAX = 4'd5;

    // Number of accumulate steps after the hours-tens digit is loaded.
    localparam logic [2:0] CONV_STEPS = 3'd7;

    // Radix applied at step k (k = 1..7) lives at index k-1.
    // Step order: hr ones, min tens, min ones, sec tens, sec ones, cs tens, cs ones.
    localparam logic [6:0][3:0] RADIX_TBL = {
        4'd10,  // step 7: cs ones
        4'd10,  // step 6: cs tens
        4'd10,  // step 5: sec ones
        4'd6,   // step 4: sec tens
        4'd10,  // step 3: min ones
        4'd6,   // step 2: min tens
        4'd10   // step 1: hr ones
    };

    // Pull one BCD digit out of the packed time word.
    function automatic logic [DIGIT_W-1:0] get_digit(input logic [WORD_W-1:0] v,
                                                     input int idx);
        return v[idx*DIGIT_W +: DIGIT_W];
    endfunction

    // Multiply by 10 or 6 using only shifts and adds. Any other radix
    // passes the value through; the table never holds one.
    function automatic logic [31:0] radix_mul(input logic [31:0] a,
                                              input logic [3:0]  r);
        logic [31:0] res;
        case (r)
            4'd10:   res = (a << 3) + (a << 1);
            4'd6:    res = (a << 2) + (a << 1);
            default: res = a;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dec2bin_bcd_time_check.sv
// bcd_time_check
//   Combinational legality check of a packed HH:MM:SS:CC BCD word.
//   err = 1 when any digit is above 9, or the minutes/seconds tens digit
//   is above 5. Hours may be anything from 00 to 99.
// Ports:
//   bcd  input  32  packed BCD time, hours tens in the top nibble
//   err  output  1  the word is not a legal time
module bcd_time_check
    import dec2bin_pkg::*;
(
    input  logic [WORD_W-1:0] bcd,
    output logic              err
);

    logic [NUM_DIGITS-1:0] over_nine;
    logic                  min_tens_bad;
    logic                  sec_tens_bad;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign over_nine[g] = (bcd[g*DIGIT_W +: DIGIT_W] > DIGIT_MAX);
    end

    assign min_tens_bad = (get_digit(bcd, DIG_MIN_TENS) > TENS60_MAX);
    assign sec_tens_bad = (get_digit(bcd, DIG_SEC_TENS) > TENS60_MAX);

    assign err = (|over_nine) | min_tens_bad | sec_tens_bad;

endmodule

// File: rtl/dec2bin.sv
// dec2bin
//   Sequential BCD time (HH:MM:SS:CC) to binary centisecond converter.
//   A value is accepted in IDLE, then seven Horner steps of
//   acc = acc*R + digit fold in the remaining digits, one per cycle, using
//   shift-add multiplies. The result is presented with a valid/ready
//   handshake. Fixed latency: out_valid rises 8 edges after acceptance.
// Ports:
//   clk        input   1  clock, rising edge
//   rst        input   1  synchronous active-high reset
//   in_valid   input   1  bcd_in is valid
//   in_ready   output  1  block can accept (IDLE only)
//   bcd_in     input  32  packed BCD time, hours tens in [31:28]
//   out_valid  output  1  result available
//   out_ready  input   1  consumer takes the result
//   bin_out    output 32  ((H*60+M)*60+S)*100+C, or 0 when err
//   err        output  1  input was not a legal time, qualified by out_valid
module dec2bin
    import dec2bin_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] bcd_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] bin_out,
    output logic        err
);

    state_e      state_q, state_d;
    logic [31:0] sreg_q;      // remaining digits, next one in the top nibble
    logic [31:0] acc_q;
    logic [2:0]  step_q;
    logic        err_q;       // legality result latched at acceptance
    logic        chk_err;

    logic        load;
    logic        conv_en;
    logic        finish;      // first DONE cycle: publish the result
    logic        release_en;  // handshake completes this edge

    bcd_time_check u_check (
        .bcd (bcd_in),
        .err (chk_err)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)               state_d = CONV;
            CONV:    if (step_q == CONV_STEPS)   state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs / datapath enables
    // ---------------------------------------------------------------
    always_comb begin
        in_ready   = (state_q == IDLE);
        load       = (state_q == IDLE) && in_valid;
        conv_en    = (state_q == CONV);
        // out_valid is registered, so DONE spends one cycle publishing
        // before the result is visible; that gives the 8-edge latency.
        finish     = (state_q == DONE) && !out_valid;
        release_en = (state_q == DONE) && out_valid && out_ready;
    end

    // ---------------------------------------------------------------
    // Digit shift register, step counter and Horner accumulator
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            acc_q  <= '0;
            step_q <= '0;
            err_q  <= 1'b0;
        end else if (load) begin
            // Hours tens seeds the accumulator; the rest queue up behind it.
            sreg_q <= {bcd_in[27:0], 4'h0};
            acc_q  <= {28'd0, bcd_in[31:28]};
            step_q <= 3'd1;
            err_q  <= chk_err;
        end else if (conv_en) begin
            acc_q  <= radix_mul(acc_q, RADIX_TBL[step_q - 3'd1])
                      + {28'd0, sreg_q[31:28]};
            sreg_q <= {sreg_q[27:0], 4'h0};
            // Wraps 7 -> 0 on the last step, leaving the counter idle.
            step_q <= step_q + 3'd1;
        end
    end

    // ---------------------------------------------------------------
    // Result registers, held stable for as long as out_ready stays low
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
            err       <= 1'b0;
        end else if (finish) begin
            out_valid <= 1'b1;
            bin_out   <= err_q ? 32'd0 : acc_q;
            err       <= err_q;
        end else if (release_en) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dec2bin.sv
module tb_dec2bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] bin_out;
    logic        err;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dec2bin dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: decode the digits as decimal numbers and compute the
    // centisecond count directly.
    function automatic void model(input logic [31:0] v, output logic [31:0] b, output logic e);
        int d [8];
        int h, m, s, c;
        for (int i = 0; i < 8; i++) d[i] = int'(v[4*i +: 4]);
        e = 1'b0;
        for (int i = 0; i < 8; i++) if (d[i] > 9) e = 1'b1;
        if (d[5] > 5 || d[3] > 5) e = 1'b1;
        h = d[7]*10 + d[6];
        m = d[5]*10 + d[4];
        s = d[3]*10 + d[2];
        c = d[1]*10 + d[0];
        b = e ? 32'd0 : 32'(((h*60 + m)*60 + s)*100 + c);
    endfunction

    function automatic logic [31:0] gen_val();
        logic [31:0] v;
        if ($urandom_range(0, 3) == 0) begin
            v = $urandom();
        end else begin
            v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
        return v;
    endfunction

    // Drive one value through: wait for in_ready, accept, measure latency,
    // hold backpressure for `hold` cycles, then release. With `chain` set,
    // in_valid stays high with `nxt` on bcd_in so it is ready to be taken
    // right after release.
    task automatic apply(input logic [31:0] v, input int hold, input bit chain,
                         input logic [31:0] nxt);
        logic [31:0] eb;
        logic        ee;
        int          n;
        model(v, eb, ee);
        in_valid = 1'b1;
        bcd_in   = v;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1;  // acceptance edge
        if (chain) begin
            bcd_in = nxt;
        end else begin
            in_valid = 1'b0;
            bcd_in   = $urandom();
        end
        n = 0;
        while (!out_valid && n < 20) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'd8);
        chk("bin_out", bin_out, eb);
        chk("err", 32'(err), 32'(ee));
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_bin", bin_out, eb);
            chk("bp_err", 32'(err), 32'(ee));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rel_valid", 32'(out_valid), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] v, nxt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bin", bin_out, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Directed cases.
        apply(32'h00000000, 0, 1'b0, 32'h0);
        apply(32'h01020304, 1, 1'b0, 32'h0);
        chk("ref_372304", bin_out, 32'd372304);
        apply(32'h99595999, 0, 1'b0, 32'h0);
        chk("ref_max", bin_out, 32'd35999999);
        apply(32'h00600000, 2, 1'b0, 32'h0);
        chk("ref_min60_err", 32'(err), 32'd1);
        apply(32'h000000A0, 0, 1'b0, 32'h0);
        chk("ref_nonbcd_err", 32'(err), 32'd1);

        // Backpressure with in_valid held high and new data waiting.
        apply(32'h12345678, 5, 1'b1, 32'h00010203);
        apply(32'h00010203, 0, 1'b0, 32'h0);

        // Reset in the middle of a conversion.
        in_valid = 1'b1;
        bcd_in   = 32'h23595999;
        @(posedge clk); #1;  // accepted
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_bin", bin_out, 32'd0);
        apply(32'h00000100, 0, 1'b0, 32'h0);
        chk("after_rst_100", bin_out, 32'd100);

        // Randomized traffic.
        v = gen_val();
        for (int k = 0; k < 60; k++) begin
            nxt = gen_val();
            apply(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), nxt);
            v = nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
